// File: rtl/neogeo_pkg.sv
// Shared NeoGeo video timing types and constants used by the frontend, the
// sync supervisor and the scaler configuration path.
package neogeo_pkg;

   localparam int unsigned VCLKS_W           = 22;
   localparam int unsigned NEO_VCLKS_NOMINAL = 101376;   // 384 * 264
   localparam int unsigned NEO_MIN_VCLKS     = 90000;
   localparam int unsigned NEO_MAX_VCLKS     = 110000;
   localparam int unsigned NEO_VCLKS_TOL     = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      ACQUIRE,
      CONFIG,
      LOCKED
   } lock_state_t;

   // Unsigned absolute difference, never wraps.
   function automatic logic [VCLKS_W-1:0] abs_diff(input logic [VCLKS_W-1:0] a,
                                                   input logic [VCLKS_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/neogeo_frame_watchdog.sv
// Saturating VCLK counter since the last frame start; flags when the
// terminal count is reached.
module neogeo_frame_watchdog #(
   parameter int unsigned TIMEOUT = 250000
) (
   input  logic VCLK_i,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic expired_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;

   // Held at zero while disabled so a fresh enable starts a full timeout.
   always_ff @(posedge VCLK_i or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (!en || clr) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_W'(TIMEOUT)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign expired_c = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/neogeo_sync_lock_ctrl.sv
// Sync lock supervisor: qualifies frame lengths, locks after a run of
// consistent frames, hands the length to the PLL/scaler and gates DE.
module neogeo_sync_lock_ctrl
   import neogeo_pkg::*;
#(
   parameter int unsigned STABLE_FRAMES = 4,
   parameter int unsigned TOL           = NEO_VCLKS_TOL,
   parameter int unsigned MIN_VCLKS     = NEO_MIN_VCLKS,
   parameter int unsigned MAX_VCLKS     = NEO_MAX_VCLKS,
   parameter int unsigned MISS_LIMIT    = 3,
   parameter int unsigned TIMEOUT_VCLKS = 250000
) (
   input  logic               VCLK_i,
   input  logic               reset_n,
   input  logic               frame_change_i,
   input  logic [VCLKS_W-1:0] vclks_per_frame_i,
   input  logic               DE_i,
   input  logic               cfg_ack_i,
   output logic               cfg_req_o,
   output logic [VCLKS_W-1:0] cfg_vclks_o,
   output logic               locked_o,
   output logic               output_en_o,
   output logic               DE_o,
   output logic               lock_lost_o
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned MISS_W = 3;

   lock_state_t        state_q,   state_d;
   logic [VCLKS_W-1:0] ref_q,     ref_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [MISS_W-1:0]  miss_q,    miss_d;
   logic               abort_q,   abort_d;
   logic               req_q,     req_d;
   logic [VCLKS_W-1:0] cfgv_q,    cfgv_d;
   logic               lost_q,    lost_d;
   logic               oen_q,     oen_d;
   logic               locked_q;
   logic               de_q;

   logic               wdog_expired_c;
   logic               wdog_hit;
   logic               frame_valid;
   logic               frame_match;
   logic               abort_set;
   logic [CNT_W-1:0]   cnt_inc;
   logic [MISS_W-1:0]  miss_inc;

   neogeo_frame_watchdog #(
      .TIMEOUT (TIMEOUT_VCLKS)
   ) u_wdog (
      .VCLK_i    (VCLK_i),
      .reset_n   (reset_n),
      .en        (state_q != IDLE),
      .clr       (frame_change_i),
      .expired_c (wdog_expired_c)
   );

   // A frame start in the same cycle as expiry restarts the count, so it wins.
   assign wdog_hit    = wdog_expired_c & ~frame_change_i;
   assign frame_valid = (vclks_per_frame_i >= VCLKS_W'(MIN_VCLKS)) &&
                        (vclks_per_frame_i <= VCLKS_W'(MAX_VCLKS));
   assign frame_match = frame_valid &&
                        (abs_diff(vclks_per_frame_i, ref_q) <= VCLKS_W'(TOL));
   assign cnt_inc     = cnt_q + CNT_W'(1);
   assign miss_inc    = miss_q + MISS_W'(1);
   assign abort_set   = (frame_change_i & ~frame_match) | wdog_hit;

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      cnt_d   = cnt_q;
      miss_d  = miss_q;
      abort_d = abort_q;
      req_d   = req_q;
      cfgv_d  = cfgv_q;
      lost_d  = 1'b0;
      oen_d   = oen_q;

      case (state_q)
         IDLE: begin
            // First measurement after (re)start covers a partial frame.
            if (frame_change_i) begin
               state_d = SETTLE;
            end
         end

         SETTLE: begin
            if (frame_change_i && frame_valid) begin
               ref_d   = vclks_per_frame_i;
               cnt_d   = CNT_W'(1);
               state_d = ACQUIRE;
            end else if (wdog_hit) begin
               state_d = IDLE;
            end
         end

         ACQUIRE: begin
            if (frame_change_i) begin
               if (frame_match) begin
                  if (cnt_inc == CNT_W'(STABLE_FRAMES)) begin
                     cfgv_d  = ref_q;
                     req_d   = 1'b1;
                     abort_d = 1'b0;
                     state_d = CONFIG;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else if (frame_valid) begin
                  ref_d = vclks_per_frame_i;
                  cnt_d = CNT_W'(1);
               end else begin
                  state_d = SETTLE;
               end
            end else if (wdog_hit) begin
               state_d = IDLE;
            end
         end

         CONFIG: begin
            // Request is never withdrawn early; a bad frame only poisons the ack.
            if (cfg_ack_i) begin
               req_d   = 1'b0;
               abort_d = 1'b0;
               if (abort_q || abort_set) begin
                  lost_d  = 1'b1;
                  state_d = SETTLE;
               end else begin
                  miss_d  = '0;
                  state_d = LOCKED;
               end
            end else if (abort_set) begin
               abort_d = 1'b1;
            end
         end

         LOCKED: begin
            if (frame_change_i) begin
               if (frame_match) begin
                  miss_d = '0;
               end else if (miss_inc == MISS_W'(MISS_LIMIT)) begin
                  miss_d  = '0;
                  lost_d  = 1'b1;
                  state_d = SETTLE;
               end else begin
                  miss_d = miss_inc;
               end
            end else if (wdog_hit) begin
               lost_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Open the gate only at a frame boundary inside lock, close on exit.
      if (state_d != LOCKED) begin
         oen_d = 1'b0;
      end else if ((state_q == LOCKED) && frame_change_i) begin
         oen_d = 1'b1;
      end
   end

   always_ff @(posedge VCLK_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         ref_q    <= '0;
         cnt_q    <= '0;
         miss_q   <= '0;
         abort_q  <= 1'b0;
         req_q    <= 1'b0;
         cfgv_q   <= '0;
         lost_q   <= 1'b0;
         oen_q    <= 1'b0;
         locked_q <= 1'b0;
         de_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ref_q    <= ref_d;
         cnt_q    <= cnt_d;
         miss_q   <= miss_d;
         abort_q  <= abort_d;
         req_q    <= req_d;
         cfgv_q   <= cfgv_d;
         lost_q   <= lost_d;
         oen_q    <= oen_d;
         locked_q <= (state_d == LOCKED);
         de_q     <= DE_i & oen_q;
      end
   end

   assign cfg_req_o   = req_q;
   assign cfg_vclks_o = cfgv_q;
   assign locked_o    = locked_q;
   assign output_en_o = oen_q;
   assign DE_o        = de_q;
   assign lock_lost_o = lost_q;

endmodule

// File: tb/tb_neogeo_sync_lock_ctrl.sv
// Directed bench for neogeo_sync_lock_ctrl with hand-computed expectations.
module tb_neogeo_sync_lock_ctrl;

   localparam int unsigned TIMEOUT = 200;
   localparam int unsigned GAP     = 8;
   localparam int unsigned NOM     = 101376;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        frame_change;
   logic [21:0] vpf;
   logic        de_in;
   logic        ack;
   logic        cfg_req;
   logic [21:0] cfg_vclks;
   logic        locked;
   logic        oen;
   logic        de_out;
   logic        lost;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   neogeo_sync_lock_ctrl #(
      .STABLE_FRAMES (4),
      .TOL           (16),
      .MIN_VCLKS     (90000),
      .MAX_VCLKS     (110000),
      .MISS_LIMIT    (3),
      .TIMEOUT_VCLKS (TIMEOUT)
   ) dut (
      .VCLK_i            (clk),
      .reset_n           (reset_n),
      .frame_change_i    (frame_change),
      .vclks_per_frame_i (vpf),
      .DE_i              (de_in),
      .cfg_ack_i         (ack),
      .cfg_req_o         (cfg_req),
      .cfg_vclks_o       (cfg_vclks),
      .locked_o          (locked),
      .output_en_o       (oen),
      .DE_o              (de_out),
      .lock_lost_o       (lost)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [21:0] v);
      repeat (GAP) tick();
      frame_change = 1'b1;
      vpf          = v;
      tick();
      frame_change = 1'b0;
      vpf          = '0;
   endtask

   task automatic do_reset();
      reset_n      = 1'b0;
      frame_change = 1'b0;
      vpf          = '0;
      ack          = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   // Five nominal frames from IDLE then an immediate ack lands in LOCKED.
   task automatic lock_up();
      repeat (5) frame(22'(NOM));
      ack_pulse();
   endtask

   initial begin
      int  n;
      bit  seen;
      logic [21:0] alt;
      de_in = 1'b1;

      // 1: reset state and acquisition to CONFIG
      reset_n      = 1'b0;
      frame_change = 1'b0;
      vpf          = '0;
      ack          = 1'b0;
      repeat (2) tick();
      check("rst_req", 32'(cfg_req), 0);
      check("rst_vclks", 32'(cfg_vclks), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_oen", 32'(oen), 0);
      check("rst_de", 32'(de_out), 0);
      check("rst_lost", 32'(lost), 0);
      reset_n = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) begin
         frame(22'(NOM));
         check($sformatf("acq_req_f%0d", i), 32'(cfg_req), 0);
      end
      frame(22'(NOM));
      check("cfg_req_f5", 32'(cfg_req), 1);
      check("cfg_vclks_f5", 32'(cfg_vclks), NOM);
      frame(22'(NOM));
      check("cfg_hold_f6", 32'(cfg_req), 1);

      // 2: ack three cycles later, gate opens at next frame start
      repeat (3) begin
         tick();
         check("cfg_req_wait", 32'(cfg_req), 1);
         check("cfg_vclks_wait", 32'(cfg_vclks), NOM);
      end
      ack_pulse();
      check("lock_after_ack", 32'(locked), 1);
      check("req_drop_ack", 32'(cfg_req), 0);
      check("oen_before_frame", 32'(oen), 0);
      check("de_gated", 32'(de_out), 0);
      frame(22'(NOM));
      check("oen_at_frame", 32'(oen), 1);
      check("de_lag", 32'(de_out), 0);
      tick();
      check("de_pass", 32'(de_out), 1);
      de_in = 1'b0;
      tick();
      check("de_low", 32'(de_out), 0);
      de_in = 1'b1;

      // 3: miss counting to loss, then recovery starts from SETTLE
      frame(22'(NOM));
      frame(22'(101390));
      frame(22'(101500));
      frame(22'(101500));
      check("miss2_nolost", 32'(lost), 0);
      check("miss2_locked", 32'(locked), 1);
      frame(22'(101500));
      check("miss3_lost", 32'(lost), 1);
      check("miss3_unlocked", 32'(locked), 0);
      check("miss3_oen", 32'(oen), 0);
      tick();
      check("lost_pulse_end", 32'(lost), 0);
      repeat (3) frame(22'(NOM));
      check("settle_req3", 32'(cfg_req), 0);
      frame(22'(NOM));
      check("settle_req4", 32'(cfg_req), 1);

      // 3b: tolerance edge, diff 16 matches, diff 17 misses
      do_reset();
      lock_up();
      frame(22'(101500));
      frame(22'(101360));
      frame(22'(101500));
      frame(22'(101500));
      check("tol16_nolost", 32'(lost), 0);
      frame(22'(101393));
      check("tol17_lost", 32'(lost), 1);

      // 4b: range edges, 110001 rejected and 110000 accepted
      do_reset();
      frame(22'(NOM));
      frame(22'(110001));
      frame(22'(89999));
      repeat (3) frame(22'(110000));
      check("max_req3", 32'(cfg_req), 0);
      frame(22'(110000));
      check("max_req4", 32'(cfg_req), 1);
      check("max_vclks", 32'(cfg_vclks), 110000);

      // 4: alternating lengths never accumulate
      do_reset();
      frame(22'(NOM));
      for (int i = 0; i < 8; i++) begin
         alt = (i % 2 == 0) ? 22'(NOM) : 22'(101420);
         frame(alt);
         check($sformatf("alt_req%0d", i), 32'(cfg_req), 0);
      end
      repeat (2) frame(22'(101420));
      check("alt_run3", 32'(cfg_req), 0);
      frame(22'(101420));
      check("alt_run4", 32'(cfg_req), 1);
      check("alt_vclks", 32'(cfg_vclks), 101420);

      // 5: bad frame during CONFIG poisons the ack
      frame(22'(80000));
      check("abort_req_held", 32'(cfg_req), 1);
      check("abort_vclks_held", 32'(cfg_vclks), 101420);
      repeat (2) tick();
      ack_pulse();
      check("abort_req_drop", 32'(cfg_req), 0);
      check("abort_lost", 32'(lost), 1);
      check("abort_unlocked", 32'(locked), 0);
      tick();
      check("abort_pulse_end", 32'(lost), 0);
      repeat (3) frame(22'(NOM));
      check("abort_settle3", 32'(cfg_req), 0);
      frame(22'(NOM));
      check("abort_settle4", 32'(cfg_req), 1);

      // 6: watchdog loss from LOCKED, then reset during CONFIG
      do_reset();
      lock_up();
      ack_pulse();
      check("stray_ack_locked", 32'(locked), 1);
      frame(22'(NOM));
      check("wd_oen", 32'(oen), 1);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 400) begin
         tick();
         n++;
         if (lost) seen = 1'b1;
      end
      check("wd_fired", 32'(seen), 1);
      check("wd_cycles", 32'(n), TIMEOUT + 1);
      check("wd_unlocked", 32'(locked), 0);
      check("wd_oen_off", 32'(oen), 0);
      repeat (4) frame(22'(NOM));
      check("wd_idle_req4", 32'(cfg_req), 0);
      frame(22'(NOM));
      check("wd_idle_req5", 32'(cfg_req), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_req", 32'(cfg_req), 0);
      check("async_rst_vclks", 32'(cfg_vclks), 0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
